// File: rtl/fp_result_pkg.sv
// fp_result_pkg: shared types, result-type codes, flag indices and format helpers
package fp_result_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } rnd_mode_e;

    localparam logic [5:0] TYPE_NAN  = 6'b000001;
    localparam logic [5:0] TYPE_INV  = 6'b000010;
    localparam logic [5:0] TYPE_INF  = 6'b000100;
    localparam logic [5:0] TYPE_ZERO = 6'b001000;
    localparam logic [5:0] TYPE_SUB  = 6'b010000;
    localparam logic [5:0] TYPE_NORM = 6'b100000;

    localparam int FLAG_INVALID   = 0;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_INEXACT   = 3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emin(input int exp_w);
        return 1 - fp_bias(exp_w);
    endfunction

    function automatic int fp_emax(input int exp_w);
        return fp_bias(exp_w);
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds, overflow-checks and encodes one lane, producing its flag contributions
module fp_round_pack
    import fp_result_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  rnd_mode_e               rnd_mode,
    input  logic [2:0]              ext_cls,
    input  logic                    ext_sign,
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] expo,
    input  logic [MAN_W:0]          sig,
    input  logic [2:0]              grs,
    input  logic                    zero,
    input  logic                    tiny,
    output logic [EXP_W+MAN_W:0]    data,
    output logic [5:0]              dtype,
    output logic [3:0]              flags
);
    localparam int BIAS = fp_bias(EXP_W);
    localparam int EMAX = fp_emax(EXP_W);
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [EXP_W-1:0] E_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0] M_ONES = '1;
    localparam logic [MAN_W-1:0] M_ZERO = '0;
    localparam logic [MAN_W-1:0] M_QNAN = {1'b1, {(MAN_W-1){1'b0}}};

    logic inc, carry, hidden, ovf, to_inf, inexact;
    logic [MAN_W+1:0] rsum;
    logic [MAN_W-1:0] mant;
    logic [EXP_W-1:0] efield;
    int rexp;

    // round the significand, then pick the encoding by class with extremes first
    always_comb begin
        inc = rnd_mode == RNE ? grs[2] & (grs[1] | grs[0] | sig[0]) :
              rnd_mode == RUP ? ~sign & (|grs) :
              rnd_mode == RDN ? sign & (|grs) : 1'b0;
        rsum = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
        carry = rsum[MAN_W+1];
        hidden = carry | rsum[MAN_W];
        mant = carry ? M_ZERO : rsum[MAN_W-1:0];
        rexp = int'(expo) + int'(carry);
        efield = EXP_W'(rexp + BIAS);
        ovf = rexp > EMAX;
        to_inf = (rnd_mode == RNE) | ((rnd_mode == RUP) & ~sign) | ((rnd_mode == RDN) & sign);
        inexact = (|grs) | ovf;
        data = '0;
        dtype = '0;
        flags = '0;
        if (ext_cls[0]) begin
            data = {ext_sign, E_ONES, M_ONES};
            dtype = TYPE_NAN;
        end else if (ext_cls[1]) begin
            data = {ext_sign, E_ONES, M_QNAN};
            dtype = TYPE_INV;
            flags[FLAG_INVALID] = 1'b1;
        end else if (ext_cls[2]) begin
            data = {ext_sign, E_ONES, M_ZERO};
            dtype = TYPE_INF;
        end else if (zero) begin
            data = {sign, {EXP_W{1'b0}}, M_ZERO};
            dtype = TYPE_ZERO;
        end else if (ovf) begin
            data = to_inf ? {sign, E_ONES, M_ZERO} : {sign, E_MAXF, M_ONES};
            dtype = to_inf ? TYPE_INF : TYPE_NORM;
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT] = 1'b1;
        end else begin
            data = {sign, hidden ? efield : {EXP_W{1'b0}}, mant};
            dtype = hidden ? TYPE_NORM : (|mant) ? TYPE_SUB : TYPE_ZERO;
            flags[FLAG_INEXACT] = inexact;
            flags[FLAG_UNDERFLOW] = tiny & inexact;
        end
    end

endmodule

// File: rtl/final_result_pipe.sv
// final_result_pipe: two-stage valid/ready result packer with denormalisation, rounding and sticky flags
module final_result_pipe
    import fp_result_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int LANES = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [1:0]                       RND_MODE,
    input  logic [3*LANES-1:0]               EXT_TYPE,
    input  logic [LANES-1:0]                 EXT_SIGN,
    input  logic [LANES-1:0]                 ACT_SIGN,
    input  logic [(EXP_W+2)*LANES-1:0]       ACT_EXP,
    input  logic [(MAN_W+1)*LANES-1:0]       ACT_SIG,
    input  logic [3*LANES-1:0]               ACT_GRS,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [(1+EXP_W+MAN_W)*LANES-1:0] DO,
    output logic [6*LANES-1:0]               DO_TYPE,
    output logic [3:0]                       FLAGS,
    input  logic                             FLAG_CLR
);
    localparam int EW   = EXP_W + 2;
    localparam int SW   = MAN_W + 1;
    localparam int M3   = MAN_W + 3;
    localparam int DW   = 1 + EXP_W + MAN_W;
    localparam int SH_W = $clog2(M3 + 1);
    localparam int EMIN = fp_emin(EXP_W);

    logic s1_valid, s2_valid, s1_load, s2_load, s1_take;
    rnd_mode_e s1_rnd;
    logic [LANES-1:0][3:0] lane_flags;
    logic [3:0] flag_set;

    assign s2_load   = ~s2_valid | OUT_READY;
    assign s1_load   = ~s1_valid | s2_load;
    assign s1_take   = s1_load & IN_VALID;
    assign IN_READY  = s1_load;
    assign OUT_VALID = s2_valid;

    // bundle-level valids and the rounding mode shared by all lanes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_rnd <= RNE;
        end else begin
            if (s1_load) s1_valid <= IN_VALID;
            if (s2_load) s2_valid <= s1_valid;
            if (s1_take) s1_rnd <= rnd_mode_e'(RND_MODE);
        end
    end

    // OR the flag contributions of every lane in the bundle at the output
    always_comb begin
        flag_set = '0;
        for (int i = 0; i < LANES; i++) flag_set = flag_set | lane_flags[i];
    end

    // sticky flags, set on the output handshake; a set beats a same-cycle clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) FLAGS <= '0;
        else FLAGS <= (FLAG_CLR ? 4'b0 : FLAGS) | ((OUT_VALID & OUT_READY) ? flag_set : 4'b0);
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [2:0] ext, cls, s1_cls;
        logic signed [EW-1:0] a_exp, d_exp, s1_exp;
        logic [SW-1:0] a_sig, d_sig, s1_sig;
        logic [2:0] a_grs, d_grs, s1_grs;
        logic tiny, s1_tiny, s1_zero, s1_xs, s1_sg;
        int diff;
        logic [SH_W-1:0] amt;
        logic [2*M3-1:0] wide;
        logic [DW-1:0] r_data, s2_data;
        logic [5:0] r_type, s2_type;
        logic [3:0] r_flags, s2_flags;

        assign ext   = EXT_TYPE[3*l +: 3];
        assign a_exp = ACT_EXP[EW*l +: EW];
        assign a_sig = ACT_SIG[SW*l +: SW];
        assign a_grs = ACT_GRS[3*l +: 3];

        // classify extremes by priority and shift tiny results down to EMIN, folding lost bits into sticky
        always_comb begin
            diff = EMIN - int'(a_exp);
            tiny = diff > 0;
            amt = SH_W'(diff > M3 ? M3 : diff);
            wide = {a_sig, a_grs[2:1], {M3{1'b0}}} >> amt;
            cls = ext[0] ? 3'b001 : ext[1] ? 3'b010 : ext[2] ? 3'b100 : 3'b000;
            d_exp = tiny ? EW'(EMIN) : a_exp;
            d_sig = tiny ? wide[2*M3-1 -: SW] : a_sig;
            d_grs = tiny ? {wide[M3+1:M3], (|wide[M3-1:0]) | a_grs[0]} : a_grs;
        end

        // stage-1 register, written only by an accepted bundle
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1_cls <= '0;
                s1_xs <= 1'b0;
                s1_sg <= 1'b0;
                s1_exp <= '0;
                s1_sig <= '0;
                s1_grs <= '0;
                s1_zero <= 1'b0;
                s1_tiny <= 1'b0;
            end else if (s1_take) begin
                s1_cls <= cls;
                s1_xs <= EXT_SIGN[l];
                s1_sg <= ACT_SIGN[l];
                s1_exp <= d_exp;
                s1_sig <= d_sig;
                s1_grs <= d_grs;
                s1_zero <= a_sig == '0;
                s1_tiny <= tiny;
            end
        end

        fp_round_pack #(
            .EXP_W(EXP_W),
            .MAN_W(MAN_W)
        ) u_round_pack (
            .rnd_mode (s1_rnd),
            .ext_cls  (s1_cls),
            .ext_sign (s1_xs),
            .sign     (s1_sg),
            .expo     (s1_exp),
            .sig      (s1_sig),
            .grs      (s1_grs),
            .zero     (s1_zero),
            .tiny     (s1_tiny),
            .data     (r_data),
            .dtype    (r_type),
            .flags    (r_flags)
        );

        // stage-2 register, written only when stage 1 hands over a valid bundle
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s2_data <= '0;
                s2_type <= '0;
                s2_flags <= '0;
            end else if (s2_load & s1_valid) begin
                s2_data <= r_data;
                s2_type <= r_type;
                s2_flags <= r_flags;
            end
        end

        assign DO[DW*l +: DW]     = s2_data;
        assign DO_TYPE[6*l +: 6]  = s2_type;
        assign lane_flags[l]      = s2_flags;
    end

endmodule
